// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the score display path.
// Optional macro SCORE_LEADING_BLANK_EN replaces leading zero digits with the blank code 4'hF on output load.
module score_bcd_conv #(
    parameter int BIN_W = 14,
    parameter int NDIG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*NDIG-1:0]     digits,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int WORK_W = 4 * NDIG;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint unsigned SAT_LIMIT = pow10(NDIG) - 64'd1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Per-nibble add-3 correction; nibbles never carry into each other.
    function automatic logic [WORK_W-1:0] add3(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] r;
        r = w;
        for (int i = 0; i < NDIG; i++) begin
            if (w[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = w[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = w[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef SCORE_LEADING_BLANK_EN
    // Blank every leading zero above the ones digit.
    function automatic logic [WORK_W-1:0] blank_lead(input logic [WORK_W-1:0] d);
        logic [WORK_W-1:0] r;
        logic              lead;
        r    = d;
        lead = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (lead && (d[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    logic [0:0]        state_r;
    logic [WORK_W-1:0] work_r;
    logic [BIN_W-1:0]  opnd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_pend_r;
    logic [WORK_W-1:0] digits_r;
    logic              busy_r;
    logic              done_r;
    logic              ovf_r;

    logic              sat_s;
    logic [BIN_W-1:0]  capture_s;
    logic [WORK_W-1:0] work_adj_s;
    logic [WORK_W-1:0] work_next_s;
    logic [BIN_W-1:0]  opnd_next_s;
    logic              last_s;
    logic [WORK_W-1:0] load_s;

    // Capture-side saturation and one shift-add-3 step of the datapath.
    always_comb begin
        sat_s       = 1'b0;
        capture_s   = bin;
        work_adj_s  = add3(work_r);
        work_next_s = {work_adj_s[WORK_W-2:0], opnd_r[BIN_W-1]};
        opnd_next_s = {opnd_r[BIN_W-2:0], 1'b0};
        last_s      = (cnt_r == CNT_W'(BIN_W - 1));
        if (64'(bin) > SAT_LIMIT) begin
            sat_s     = 1'b1;
            capture_s = BIN_W'(SAT_LIMIT);
        end else begin
            sat_s     = 1'b0;
            capture_s = bin;
        end
`ifdef SCORE_LEADING_BLANK_EN
        load_s = blank_lead(work_next_s);
`else
        load_s = work_next_s;
`endif
    end

    // Conversion state machine, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            work_r     <= '0;
            opnd_r     <= '0;
            cnt_r      <= '0;
            ovf_pend_r <= 1'b0;
            digits_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        opnd_r     <= capture_s;
                        ovf_pend_r <= sat_s;
                        work_r     <= '0;
                        cnt_r      <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work_r <= work_next_s;
                    opnd_r <= opnd_next_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        digits_r <= load_s;
                        ovf_r    <= ovf_pend_r;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign digits = digits_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign ovf    = ovf_r;

endmodule
